// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_array
// Purpose  : Array of N_NEURONS leaky integrate-and-fire neurons that share one
//            runtime configuration (threshold, leak shift, refractory period,
//            reset mode). One timestep is evaluated per in_valid pulse.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous, active-low reset
//            in_valid       - timestep strobe, post_synaptic valid this cycle
//            post_synaptic  - per-neuron unsigned input, neuron i at
//                             [i*DATA_W +: DATA_W]
//            cfg_we         - configuration write strobe
//            cfg_addr       - 0=threshold 1=leak_shift 2=refrac_period+mode
//                             3=clear spike_count (when enabled)
//            cfg_wdata      - configuration data
//            spike          - registered spike vector
//            spike_valid    - one-cycle pulse, one cycle after in_valid
//            spike_count    - 16-bit saturating spike counter (optional)
// Options  : define LIF_SPIKE_COUNT_EN to add the spike_count output.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_array #(
    parameter int N_NEURONS  = 8,
    parameter int DATA_W     = 8,
    parameter int REFRAC_W   = 4,
    parameter int THRESH_RST = 32,
    parameter int LEAK_RST   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [N_NEURONS*DATA_W-1:0]   post_synaptic,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_addr,
    input  logic [DATA_W-1:0]             cfg_wdata,
    output logic [N_NEURONS-1:0]          spike,
    output logic                          spike_valid
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [15:0]                   spike_count
`endif
);

    // Leak shifts at or beyond the membrane width retain nothing.
    localparam logic [DATA_W:0] c_SHIFT_LIMIT = (DATA_W+1)'(DATA_W);

    logic [DATA_W-1:0]    r_threshold;
    logic [DATA_W-1:0]    r_leak_shift;
    logic [REFRAC_W-1:0]  r_refrac_period;
    logic                 r_mode;
    logic [N_NEURONS-1:0] r_spike;
    logic                 r_spike_valid;
    logic [N_NEURONS-1:0] w_fire;
    logic                 w_shift_kill;

    assign w_shift_kill = ({1'b0, r_leak_shift} >= c_SHIFT_LIMIT);

    // Shared configuration and registered outputs. The neuron datapath reads
    // the register values, so a write coinciding with in_valid only affects
    // later timesteps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_threshold     <= DATA_W'(THRESH_RST);
            r_leak_shift    <= DATA_W'(LEAK_RST);
            r_refrac_period <= '0;
            r_mode          <= 1'b0;
            r_spike         <= '0;
            r_spike_valid   <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: r_threshold  <= cfg_wdata;
                    2'd1: r_leak_shift <= cfg_wdata;
                    2'd2: begin
                        r_refrac_period <= cfg_wdata[REFRAC_W-1:0];
                        r_mode          <= cfg_wdata[DATA_W-1];
                    end
                    default: ;
                endcase
            end
            r_spike       <= in_valid ? w_fire : '0;
            r_spike_valid <= in_valid;
        end
    end

    assign spike       = r_spike;
    assign spike_valid = r_spike_valid;

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        logic [DATA_W-1:0]   w_post;
        logic [DATA_W-1:0]   w_retained;
        logic [DATA_W:0]     w_sum_wide;
        logic [DATA_W-1:0]   w_sum;
        logic                w_refractory;
        logic                w_cross;
        logic [DATA_W-1:0]   r_membrane;
        logic [REFRAC_W-1:0] r_refrac_cnt;

        assign w_post       = post_synaptic[gi*DATA_W +: DATA_W];
        assign w_refractory = (r_refrac_cnt != '0);
        assign w_retained   = w_shift_kill ? '0 : (r_membrane >> r_leak_shift);
        assign w_sum_wide   = {1'b0, w_post} + {1'b0, w_retained};
        // Saturate the integration instead of wrapping.
        assign w_sum        = w_sum_wide[DATA_W] ? '1 : w_sum_wide[DATA_W-1:0];
        assign w_cross      = (w_sum >= r_threshold);
        assign w_fire[gi]   = !w_refractory && w_cross;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_membrane   <= '0;
                r_refrac_cnt <= '0;
            end else if (in_valid) begin
                if (w_refractory) begin
                    // Membrane frozen, input discarded while refractory.
                    r_refrac_cnt <= r_refrac_cnt - REFRAC_W'(1);
                end else if (w_cross) begin
                    r_membrane   <= r_mode ? (w_sum - r_threshold) : '0;
                    r_refrac_cnt <= r_refrac_period;
                end else begin
                    r_membrane <= w_sum;
                end
            end
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] r_spike_count;
    logic [16:0] w_count_sum;

    always_comb begin
        w_count_sum = {1'b0, r_spike_count};
        for (int k = 0; k < N_NEURONS; k++) begin
            w_count_sum = w_count_sum + 17'(w_fire[k]);
        end
    end

    // A clear via address 3 takes priority over a coincident timestep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spike_count <= '0;
        end else if (cfg_we && (cfg_addr == 2'd3)) begin
            r_spike_count <= '0;
        end else if (in_valid) begin
            r_spike_count <= w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
        end
    end

    assign spike_count = r_spike_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_array
// Purpose  : Self-checking bench for lif_neuron_array. A driver issues
//            timesteps and config writes, a reference model predicts each
//            spike vector into a queue, and a monitor compares whenever the
//            design presents spike_valid.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_array;

    localparam int N  = 8;
    localparam int DW = 8;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [N*DW-1:0] post_synaptic;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [DW-1:0]   cfg_wdata;
    logic [N-1:0]    spike;
    logic            spike_valid;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]     spike_count;
`endif

    lif_neuron_array #(
        .N_NEURONS (N),
        .DATA_W    (DW),
        .REFRAC_W  (4),
        .THRESH_RST(32),
        .LEAK_RST  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .post_synaptic(post_synaptic),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .spike        (spike),
        .spike_valid  (spike_valid)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count  (spike_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0] spk;
        int           due;
        int           cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state, held as plain integers.
    int m_mem [N];
    int m_ref [N];
    int m_thr, m_leak, m_rp, m_mode, m_cnt;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0;
            m_ref[i] = 0;
        end
        m_thr = 32; m_leak = 4; m_rp = 0; m_mode = 0; m_cnt = 0;
    endtask

    // Driver: one cycle of stimulus; the model predicts with pre-write config.
    task automatic drive(input bit iv, input logic [N*DW-1:0] post,
                         input bit we, input logic [1:0] addr, input logic [DW-1:0] wd);
        logic [N-1:0] fire;
        exp_t e;
        @(negedge clk);
        in_valid      = iv;
        post_synaptic = post;
        cfg_we        = we;
        cfg_addr      = addr;
        cfg_wdata     = wd;
        fire = '0;
        if (iv) begin
            for (int i = 0; i < N; i++) begin
                int inp, ret, sum;
                inp = int'(post[i*DW +: DW]);
                if (m_ref[i] > 0) begin
                    m_ref[i] = m_ref[i] - 1;
                end else begin
                    ret = (m_leak >= DW) ? 0 : (m_mem[i] / (1 << m_leak));
                    sum = inp + ret;
                    if (sum > 255) sum = 255;
                    if (sum >= m_thr) begin
                        fire[i]  = 1'b1;
                        m_mem[i] = m_mode ? (sum - m_thr) : 0;
                        m_ref[i] = m_rp;
                    end else begin
                        m_mem[i] = sum;
                    end
                end
            end
            for (int i = 0; i < N; i++) m_cnt += int'(fire[i]);
            if (m_cnt > 65535) m_cnt = 65535;
        end
        if (we) begin
            case (addr)
                2'd0: m_thr  = int'(wd);
                2'd1: m_leak = int'(wd);
                2'd2: begin m_rp = int'(wd[3:0]); m_mode = int'(wd[7]); end
                default: m_cnt = 0;
            endcase
        end
        if (iv) begin
            e.spk = fire;
            e.due = cyc + 1;
            e.cnt = m_cnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic stepv(input logic [N*DW-1:0] post);
        drive(1'b1, post, 1'b0, 2'd0, '0);
    endtask

    task automatic cfg(input logic [1:0] addr, input logic [DW-1:0] wd);
        drive(1'b0, '0, 1'b1, addr, wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("reset_spike_valid", int'(spike_valid), 0);
        chk("reset_spike", int'(spike), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: compares each presented result against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            if (spike_valid) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    chk("unexpected_spike_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("spike_vector", int'(spike), int'(e.spk));
`ifdef LIF_SPIKE_COUNT_EN
                    chk("spike_count", int'(spike_count), e.cnt);
`endif
                end
            end else begin
                chk("idle_spike_zero", int'(spike), 0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    void'(exp_q.pop_front());
                    chk("missing_spike_valid", 0, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] pv;
        reset         = 1'b0;
        in_valid      = 1'b0;
        post_synaptic = '0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_wdata     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("por_spike_valid", int'(spike_valid), 0);
        chk("por_spike", int'(spike), 0);
        @(negedge clk);
        reset = 1'b1;

        // Defaults: input 20 everywhere settles at 21 and never fires.
        for (int s = 0; s < 10; s++) stepv({N{8'd20}});

        // Leak path, mode 0.
        do_reset();
        cfg(2'd1, 8'd1);
        for (int s = 0; s < 4; s++) stepv({56'd0, 8'd20});

        // Subtract mode with refractory period 2.
        do_reset();
        cfg(2'd1, 8'd1);
        cfg(2'd2, 8'h82);
        for (int s = 0; s < 7; s++) stepv({56'd0, 8'd20});

        // Saturation on neuron 7.
        do_reset();
        cfg(2'd0, 8'd255);
        cfg(2'd1, 8'd0);
        for (int s = 0; s < 3; s++) stepv({8'd200, 56'd0});

        // Config write colliding with a timestep.
        do_reset();
        drive(1'b1, {N{8'd15}}, 1'b1, 2'd0, 8'd10);
        stepv({N{8'd15}});

        // Back-to-back fires at threshold 0 with mode 1.
        cfg(2'd0, 8'd0);
        cfg(2'd2, 8'h80);
        for (int s = 0; s < 3; s++) stepv({N{8'd3}});

        // Async reset during a timestep discards it and clears membranes.
        do_reset();
        stepv({N{8'd20}});
        stepv({N{8'd20}});
        @(negedge clk);
        in_valid      = 1'b1;
        post_synaptic = {N{8'd20}};
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        chk("midreset_no_valid", int'(spike_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        stepv({N{8'd31}});
        stepv({N{8'd31}});

        // Randomized traffic with interleaved config writes.
        for (int it = 0; it < 300; it++) begin
            bit          iv, we;
            logic [1:0]  addr;
            logic [7:0]  wd;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) pv[i*DW +: DW] = 8'($urandom_range(0, 255));
                else                           pv[i*DW +: DW] = 8'($urandom_range(0, 40));
            end
            iv   = ($urandom_range(0, 9) < 7);
            we   = ($urandom_range(0, 9) < 2);
            addr = 2'($urandom_range(0, 3));
            case (addr)
                2'd0:    wd = 8'($urandom_range(0, 120));
                2'd1:    wd = 8'($urandom_range(0, 10));
                default: wd = 8'($urandom_range(0, 255));
            endcase
            drive(iv, pv, we, addr, wd);
        end

        drive(1'b0, '0, 1'b0, 2'd0, '0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
